// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and helpers for the RV32M multiply/divide sequencer
package muldiv_pkg;

   localparam int XLEN_DEF = 32;

   // Encoding follows the funct3 field of the M-extension instructions.
   typedef enum logic [2:0] {
      MUL    = 3'b000,
      MULH   = 3'b001,
      MULHSU = 3'b010,
      MULHU  = 3'b011,
      DIV    = 3'b100,
      DIVU   = 3'b101,
      REM    = 3'b110,
      REMU   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } md_state_e;

   function automatic logic is_div(input md_op_e op);
      return op[2];
   endfunction

   function automatic logic rs1_signed(input md_op_e op);
      return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
   endfunction

   function automatic logic rs2_signed(input md_op_e op);
      return (op == MULH) || (op == DIV) || (op == REM);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add / restoring-divide iteration
//
// Ports:
//   div_op   : 1 = restoring divide step, 0 = shift-add multiply step
//   acc      : 2*XLEN+1 accumulator
//              multiply: acc[2*XLEN-1:0] = {partial high, remaining multiplier}
//              divide  : acc[2*XLEN:XLEN] = remainder, acc[XLEN-1:0] = quotient/dividend
//   operand  : multiplicand (multiply) or divisor (divide), magnitude only
//   acc_next : accumulator after this iteration
//   q_bit    : quotient bit produced by a divide step (0 for multiply)
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic              div_op,
   input  logic [2*XLEN:0]   acc,
   input  logic [XLEN-1:0]   operand,
   output logic [2*XLEN:0]   acc_next,
   output logic              q_bit
);

   logic [XLEN:0] sum;
   logic [XLEN:0] rem_shift;
   logic [XLEN:0] rem_new;
   logic          ge;

   always_comb begin
      sum       = '0;
      rem_shift = '0;
      rem_new   = '0;
      ge        = 1'b0;
      acc_next  = acc;
      q_bit     = 1'b0;
      if (div_op) begin
         // Remainder stays below the divisor, so the shifted value fits in XLEN+1 bits.
         rem_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
         ge        = (rem_shift >= {1'b0, operand});
         rem_new   = ge ? (rem_shift - {1'b0, operand}) : rem_shift;
         acc_next  = {rem_new, acc[XLEN-2:0], ge};
         q_bit     = ge;
      end else begin
         // Add the multiplicand into the high half when the multiplier LSB is set,
         // then shift the whole product right; the carry lands in the top bit.
         sum      = acc[2*XLEN:XLEN] + (acc[0] ? {1'b0, operand} : '0);
         acc_next = {1'b0, sum, acc[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle RV32M multiply/divide controller with execute stall
//
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   md_valid   : execute stage holds an M-type instruction
//   fn3        : M-op select (MUL..REMU)
//   rs1_data   : dividend / multiplicand
//   rs2_data   : divisor / multiplier
//   flush      : squash of the execute stage, aborts any operation
//   md_ready   : sequencer idle and able to accept
//   stall_ex   : freeze PC, IF/ID and ID/EX while an operation is in flight
//   done       : one-cycle pulse, result valid
//   result     : registered operation result
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            md_valid,
   input  logic [2:0]      fn3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            flush,
   output logic            md_ready,
   output logic            stall_ex,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);

   md_state_e         state, state_nxt;
   md_op_e            op_in, op_q;
   logic [CW-1:0]     cnt;
   logic              neg_q;
   logic [2*XLEN:0]   acc_q;
   logic [XLEN-1:0]   opd_q;
   logic [XLEN-1:0]   result_q;

   logic              s1, s2;
   logic [XLEN-1:0]   mag1, mag2;
   logic              div_zero, div_ovf, fast;
   logic [XLEN-1:0]   fast_res;
   logic [2*XLEN:0]   step_acc;
   logic              step_q;
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0]   div_sel, fix_res;

   assign op_in = md_op_e'(fn3);

   // Operand conditioning for the incoming instruction.
   assign s1   = rs1_signed(op_in) & rs1_data[XLEN-1];
   assign s2   = rs2_signed(op_in) & rs2_data[XLEN-1];
   assign mag1 = s1 ? (~rs1_data + 1'b1) : rs1_data;
   assign mag2 = s2 ? (~rs2_data + 1'b1) : rs2_data;

   // Cases whose answer is fixed by the ISA and bypass the iteration.
   assign div_zero = (rs2_data == '0);
   assign div_ovf  = ((op_in == DIV) || (op_in == REM)) &&
                     (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
   assign fast     = is_div(op_in) && (div_zero || div_ovf);

   always_comb begin
      fast_res = '0;
      if (div_zero)
         fast_res = op_in[1] ? rs1_data : '1;   // fn3[1] set: REM/REMU
      else
         fast_res = op_in[1] ? '0 : rs1_data;   // signed overflow
   end

   muldiv_step #(.XLEN(XLEN)) u_step (
      .div_op   (is_div(op_q)),
      .acc      (acc_q),
      .operand  (opd_q),
      .acc_next (step_acc),
      .q_bit    (step_q)
   );

   // Sign correction and word selection once iteration finishes.
   always_comb begin
      prod     = acc_q[2*XLEN-1:0];
      prod_fix = neg_q ? (~prod + 1'b1) : prod;
      div_sel  = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
      fix_res  = '0;
      if (is_div(op_q))
         fix_res = neg_q ? (~div_sel + 1'b1) : div_sel;
      else if (op_q == MUL)
         fix_res = prod_fix[XLEN-1:0];
      else
         fix_res = prod_fix[2*XLEN-1:XLEN];
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic; flush overrides every transition.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (md_valid) state_nxt = fast ? DONE : CALC;
         CALC:    if (cnt == CW'(XLEN-1)) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush)
         state_nxt = IDLE;
   end

   // Outputs
   always_comb begin
      md_ready = (state == IDLE);
      done     = (state == DONE);
      stall_ex = !rst && (((state == IDLE) && md_valid) || (state == CALC) || (state == FIX));
   end

   assign result = result_q;

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= MUL;
         neg_q    <= 1'b0;
         cnt      <= '0;
         acc_q    <= '0;
         opd_q    <= '0;
         result_q <= '0;
      end else if (flush) begin
         cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (md_valid) begin
                  op_q  <= op_in;
                  cnt   <= '0;
                  // REM takes the dividend's sign; everything else the XOR.
                  neg_q <= (is_div(op_in) && op_in[1]) ? s1 : (s1 ^ s2);
                  if (fast) begin
                     result_q <= fast_res;
                  end else if (is_div(op_in)) begin
                     acc_q <= {{(XLEN+1){1'b0}}, mag1};
                     opd_q <= mag2;
                  end else begin
                     acc_q <= {{(XLEN+1){1'b0}}, mag2};
                     opd_q <= mag1;
                  end
               end
            end
            CALC: begin
               acc_q <= step_acc;
               cnt   <= (cnt == CW'(XLEN-1)) ? '0 : cnt + CW'(1);
            end
            FIX: begin
               result_q <= fix_res;
            end
            default: ;
         endcase
      end
   end

   // The quotient bit is already folded into step_acc; kept as a visible step output.
   logic unused_q;
   assign unused_q = step_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        md_valid = 1'b0;
   logic [2:0]  fn3 = 3'b000;
   logic [31:0] rs1_data = '0;
   logic [31:0] rs2_data = '0;
   logic        flush = 1'b0;
   logic        md_ready, stall_ex, done;
   logic [31:0] result;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   muldiv_sequencer #(.XLEN(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .md_valid (md_valid),
      .fn3      (fn3),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .flush    (flush),
      .md_ready (md_ready),
      .stall_ex (stall_ex),
      .done     (done),
      .result   (result)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one op and hold md_valid until the pipeline advances (edge after done).
   // lat = number of edges from acceptance (E0 counted as 1) until done is seen.
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      int cyc;
      int stall_bad;
      @(negedge clk);
      fn3 = f; rs1_data = a; rs2_data = b; md_valid = 1'b1;
      #1 check({tag, "/stall_accept"}, {31'b0, stall_ex}, 32'd1);
      cyc = 0;
      stall_bad = 0;
      while (cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (done) break;
         if (!stall_ex) stall_bad++;
      end
      check({tag, "/latency"}, cyc, lat);
      check({tag, "/stall_busy"}, stall_bad, 0);
      check({tag, "/stall_done"}, {31'b0, stall_ex}, 32'd0);
      check({tag, "/result"}, result, exp);
      @(posedge clk); #1;
      check({tag, "/done_pulse"}, {31'b0, done}, 32'd0);
      md_valid = 1'b0;
      #1 check({tag, "/ready_after"}, {31'b0, md_ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] prev;
      int done_seen;

      // Reset state, with md_valid asserted to show stall is held low by reset.
      #2 rst = 1'b1;
      md_valid = 1'b1;
      #1;
      check("reset/done", {31'b0, done}, 32'd0);
      check("reset/result", result, 32'd0);
      check("reset/ready", {31'b0, md_ready}, 32'd1);
      check("reset/stall", {31'b0, stall_ex}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      md_valid = 1'b0;
      rst = 1'b0;

      // Multiply family
      run_op("mul_neg",    3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
      run_op("mul_pos",    3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 34);
      run_op("mulh",       3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
      run_op("mulhsu",     3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
      run_op("mulhu",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);

      // Divide family
      run_op("div_neg",    3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34);
      run_op("rem_neg",    3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34);
      run_op("divu",       3'b101, 32'd100,       32'd7,         32'd14,        34);
      run_op("remu",       3'b111, 32'd100,       32'd7,         32'd2,         34);
      run_op("divu_big",   3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 34);

      // Fast paths
      run_op("divu_zero",  3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      run_op("rem_zero",   3'b110, 32'd5,         32'd0,         32'd5,         1);
      run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

      // Accept and flush at the same edge: nothing is accepted.
      @(negedge clk);
      fn3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd3; md_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      md_valid = 1'b0; flush = 1'b0;
      #1 check("acc_flush/ready", {31'b0, md_ready}, 32'd1);

      // Flush at E10 of a DIV.
      prev = result;
      @(negedge clk);
      fn3 = 3'b100; rs1_data = 32'hFFFF_FFF9; rs2_data = 32'd2; md_valid = 1'b1;
      @(posedge clk);            // E0
      repeat (9) @(posedge clk); // E9
      #1 flush = 1'b1;
      @(posedge clk); #1;        // E10
      md_valid = 1'b0; flush = 1'b0;
      #1;
      check("flush/ready", {31'b0, md_ready}, 32'd1);
      check("flush/done", {31'b0, done}, 32'd0);
      check("flush/result", result, prev);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) done_seen++;
      end
      check("flush/no_done", done_seen, 0);
      run_op("mul_after_flush", 3'b000, 32'd6, 32'd7, 32'd42, 34);

      // Asynchronous reset mid-CALC.
      @(negedge clk);
      fn3 = 3'b000; rs1_data = 32'd9; rs2_data = 32'd9; md_valid = 1'b1;
      @(posedge clk);
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("async_rst/done", {31'b0, done}, 32'd0);
      check("async_rst/result", result, 32'd0);
      check("async_rst/stall", {31'b0, stall_ex}, 32'd0);
      check("async_rst/ready", {31'b0, md_ready}, 32'd1);
      @(negedge clk);
      md_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      run_op("mul_after_rst", 3'b000, 32'd9, 32'd9, 32'd81, 34);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle controller for the RV32M multiply/divide extension, sitting beside the execute-stage ALU. It accepts an M-type instruction and its operands, runs an iterative shift-add multiply or restoring divide over 32 cycles, and applies sign correction. It holds the execute stage with a stall signal until the result is ready, then presents a one-cycle result for writeback muxing with alu_out.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
md_valid  input  1  execute stage holds an M-type instruction (opcode 0110011, funct7 0000001)
fn3  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_data  input  XLEN  dividend / multiplicand
rs2_data  input  XLEN  divisor / multiplier
flush  input  1  branch/jump squash of the execute stage; aborts the operation
md_ready  output  1  sequencer idle and able to accept
stall_ex  output  1  freeze PC and the IF/ID and ID/EX registers
done  output  1  result valid this cycle (one-cycle pulse)
result  output  XLEN  operation result, registered

Behaviour:
- Reset (async, rst=1): state IDLE, counter 0, result 0, done 0, internal operand/accumulator registers 0. stall_ex is forced to 0 while rst=1.
- States: IDLE, CALC, FIX, DONE.
- IDLE: md_ready=1. Acceptance happens at an edge where md_valid=1, flush=0 and state is IDLE (edge E0).
- At E0, the following are latched:
  - fn3.
  - Operand magnitudes. rs1 is treated as signed for MULH, MULHSU, DIV and REM. rs2 is treated as signed for MULH, DIV and REM.
  - neg_res. For multiply it is s1^s2. For DIV it is s1^s2. For REM it is s1.
- Fast path at E0 (division ops only), going straight to DONE:
  - divisor==0: DIV/DIVU give 0xFFFFFFFF. REM/REMU give rs1_data unchanged.
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: DIV gives 0x80000000, REM gives 0.
  - Otherwise go to CALC with counter=0.
- CALC, edges E1..E32, one iteration per edge:
  - Multiply: 64-bit product register, shift-add on the multiplier LSB.
  - Divide: restoring. Shift {rem,quot} left 1, trial-subtract the divisor, set the quotient LSB if the result is non-negative.
  - The counter increments each edge. At the edge where the counter reaches XLEN-1 (E32), go to FIX.
- FIX (E33):
  - Conditionally two's-complement the 64-bit product, or the quotient/remainder, per neg_res.
  - Select the low word for MUL and the high word for MULH/MULHSU/MULHU.
  - Load result and go to DONE.
- DONE: done=1 for exactly one cycle. The next edge (E34) returns to IDLE. Latency is fixed: done is high in the cycle between E33 and E34. For the fast path, done is high in the cycle after E0.
- stall_ex = (state==IDLE && md_valid) || state==CALC || state==FIX. It is 0 in DONE, so the pipeline advances at the same edge the sequencer returns to IDLE. The same instruction is never re-accepted.
- result holds its value after DONE until the next load. Writeback must use it only when done=1.
- flush has priority over everything except rst. flush=1 at any edge moves the state to IDLE, clears the counter, and suppresses done. result is unchanged. An accept and a flush at the same edge means no accept.
- md_valid dropping mid-operation (not expected) is ignored. Only flush aborts.
- All arithmetic is unsigned on magnitudes. The product is 2*XLEN wide. The remainder register is XLEN+1 wide for the trial subtract. No overflow is possible beyond the fast-path cases.

Decomposition:
- Package muldiv_pkg contains:
  - XLEN_DEF = 32.
  - Enum md_op_e, 3 bits, values MUL..REMU mapped to fn3.
  - Enum md_state_e: IDLE, CALC, FIX, DONE.
  - Helper functions is_div(op), rs1_signed(op), rs2_signed(op).
- One sub-module, muldiv_step. It is combinational and does a single iteration: given op class, accumulator and operand, it returns the next accumulator and quotient bit.
- The FSM, counter and registers live in muldiv_sequencer.

Test Plan:
1. MUL, rs1=7, rs2=0xFFFFFFFD (-3) -> result 0xFFFFFFEB. done high exactly in the cycle after E33. stall_ex high from the accept cycle through FIX, low in DONE.
2. MULH 0x80000000*0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
3. DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
4. DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both with done in the cycle after E0. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, also fast-path.
5. flush pulsed at E10 of a DIV -> state IDLE, md_ready=1 next cycle, no done pulse, result unchanged. A new MUL accepted immediately afterwards completes normally.
6. rst asserted asynchronously mid-CALC (between edges) -> done=0, result=0 and stall_ex=0 immediately. After release, IDLE accepts a new op.
